// File: rtl/riscv_ctrl_axil_slave.sv
// AXI4-Lite control/status window for the RISC-V core: ID, STATUS, CTRL, BOOT_ADDR, CYCLES, SCRATCH.
// Latency 1 cycle write (last handshake -> bvalid) and read (AR -> rvalid); one write and one read outstanding, held until bready/rready.
module riscv_ctrl_axil_slave #(
    parameter int          ADDR_W        = 6,
    parameter logic [31:0] ID_VALUE      = 32'h5253_0001,
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_0080
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic              core_sleep_i,
    output logic              reboot_o,
    output logic              fetch_enable_o,
    output logic [31:0]       boot_addr_o
);

    localparam int IW = ADDR_W - 2;
    localparam logic [IW-1:0] IDX_ID      = IW'(0);
    localparam logic [IW-1:0] IDX_STATUS  = IW'(1);
    localparam logic [IW-1:0] IDX_CTRL    = IW'(4);
    localparam logic [IW-1:0] IDX_BOOT    = IW'(5);
    localparam logic [IW-1:0] IDX_CYCLES  = IW'(6);
    localparam logic [IW-1:0] IDX_SCRATCH = IW'(7);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    logic          ready_en_q, ready_en_d;
    logic          aw_held_q, aw_held_d;
    logic [IW-1:0] aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [31:0]   w_data_q, w_data_d;
    logic [3:0]    w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          reboot_q, reboot_d;
    logic          fetch_en_q, fetch_en_d;
    logic [31:0]   boot_addr_q, boot_addr_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [31:0]   scratch_q, scratch_d;

    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, wr_mapped;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [31:0]   wr_data, rd_data;
    logic [3:0]    wr_strb;
    logic          rd_err;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign s_axi_awready  = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign s_axi_wready   = ready_en_q & ~w_held_q & ~bvalid_q;
    assign s_axi_arready  = ready_en_q & ~rvalid_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rdata    = rdata_q;
    assign s_axi_rresp    = rresp_q;
    assign reboot_o       = reboot_q;
    assign fetch_enable_o = fetch_en_q & ~reboot_q;
    assign boot_addr_o    = boot_addr_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign b_hs  = bvalid_q & s_axi_bready;
    assign r_hs  = rvalid_q & s_axi_rready;

    // Commit on the edge completing the second of the AW/W handshakes (either order, or together).
    always_comb begin
        wr_idx  = aw_hs ? s_axi_awaddr[ADDR_W-1:2] : aw_idx_q;
        wr_data = w_hs ? s_axi_wdata : w_data_q;
        wr_strb = w_hs ? s_axi_wstrb : w_strb_q;
        commit  = (aw_hs | aw_held_q) & (w_hs | w_held_q) & ~bvalid_q;
        wr_mapped = (wr_idx == IDX_ID) || (wr_idx == IDX_STATUS) || (wr_idx == IDX_CTRL) ||
                    (wr_idx == IDX_BOOT) || (wr_idx == IDX_CYCLES) || (wr_idx == IDX_SCRATCH);
    end

    always_comb begin
        rd_idx  = s_axi_araddr[ADDR_W-1:2];
        rd_data = 32'h0;
        rd_err  = 1'b0;
        case (rd_idx)
            IDX_ID:      rd_data = ID_VALUE;
            IDX_STATUS:  rd_data = {29'h0, reboot_o, fetch_enable_o, core_sleep_i};
            IDX_CTRL:    rd_data = {27'h0, fetch_en_q, 3'h0, reboot_q};
            IDX_BOOT:    rd_data = boot_addr_q;
            IDX_CYCLES:  rd_data = cycles_q;
            IDX_SCRATCH: rd_data = scratch_q;
            default:     rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        ready_en_d  = 1'b1;
        aw_held_d   = aw_held_q;
        aw_idx_d    = aw_hs ? s_axi_awaddr[ADDR_W-1:2] : aw_idx_q;
        w_held_d    = w_held_q;
        w_data_d    = w_hs ? s_axi_wdata : w_data_q;
        w_strb_d    = w_hs ? s_axi_wstrb : w_strb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        reboot_d    = reboot_q;
        fetch_en_d  = fetch_en_q;
        boot_addr_d = boot_addr_q;
        scratch_d   = scratch_q;
        cycles_d    = cycles_q;

        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        // Slots stay occupied until the response is taken, which bounds us to one write in flight.
        if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_mapped ? RESP_OKAY : RESP_SLVERR;
            case (wr_idx)
                IDX_CTRL: begin
                    if (wr_strb[0]) begin
                        reboot_d   = wr_data[0];
                        fetch_en_d = wr_data[4];
                    end
                end
                IDX_BOOT:    boot_addr_d = merge(boot_addr_q, wr_data, wr_strb);
                IDX_SCRATCH: scratch_d   = merge(scratch_q, wr_data, wr_strb);
                default: ;
            endcase
        end

        if (reboot_o)            cycles_d = 32'h0;
        else if (fetch_enable_o) cycles_d = cycles_q + 32'd1;

        if (r_hs) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ready_en_q  <= 1'b0;
            aw_held_q   <= 1'b0;
            aw_idx_q    <= '0;
            w_held_q    <= 1'b0;
            w_data_q    <= 32'h0;
            w_strb_q    <= 4'h0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            rresp_q     <= RESP_OKAY;
            reboot_q    <= 1'b0;
            fetch_en_q  <= 1'b0;
            boot_addr_q <= BOOT_ADDR_RST;
            cycles_q    <= 32'h0;
            scratch_q   <= 32'h0;
        end else begin
            ready_en_q  <= ready_en_d;
            aw_held_q   <= aw_held_d;
            aw_idx_q    <= aw_idx_d;
            w_held_q    <= w_held_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            reboot_q    <= reboot_d;
            fetch_en_q  <= fetch_en_d;
            boot_addr_q <= boot_addr_d;
            cycles_q    <= cycles_d;
            scratch_q   <= scratch_d;
        end
    end

endmodule

// File: tb/tb_riscv_ctrl_axil_slave.sv
// Directed bench for riscv_ctrl_axil_slave: vector table of single transactions plus handshake/backpressure/reset sequences.
module tb_riscv_ctrl_axil_slave;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [5:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [5:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        core_sleep_i;
    logic        reboot_o;
    logic        fetch_enable_o;
    logic [31:0] boot_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    riscv_ctrl_axil_slave dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .core_sleep_i(core_sleep_i),
        .reboot_o(reboot_o), .fetch_enable_o(fetch_enable_o), .boot_addr_o(boot_addr_o)
    );

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;

    vec_t vt[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks are entered and left on a falling edge; inputs change there, outputs sampled there.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic lat_ok);
        bit aw_done, w_done, a_f, w_f;
        int n;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            a_f = s_axi_awvalid & s_axi_awready;
            w_f = s_axi_wvalid & s_axi_wready;
            @(negedge sys_clk);
            if (a_f) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_f) begin w_done = 1; s_axi_wvalid = 1'b0; end
            n++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            lat_ok = 1'b0; resp = 2'bxx;
            return;
        end
        lat_ok = s_axi_bvalid;
        resp   = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(negedge sys_clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic lat_ok);
        bit fired;
        int n;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        fired = 0; n = 0;
        while (!fired && n < 20) begin
            fired = s_axi_arready;
            @(negedge sys_clk);
            n++;
        end
        s_axi_arvalid = 1'b0;
        if (!fired) begin
            lat_ok = 1'b0; data = 'x; resp = 2'bxx;
            return;
        end
        lat_ok = s_axi_rvalid;
        data   = s_axi_rdata;
        resp   = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(negedge sys_clk);
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, held;
        logic [1:0]  r;
        logic        ok;

        vt[0]  = '{1'b0, 6'h00, 32'h0,         4'h0, 32'h5253_0001, 2'b00};
        vt[1]  = '{1'b0, 6'h14, 32'h0,         4'h0, 32'h0000_0080, 2'b00};
        vt[2]  = '{1'b0, 6'h10, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
        vt[3]  = '{1'b0, 6'h04, 32'h0,         4'h0, 32'h0000_0001, 2'b00};
        vt[4]  = '{1'b1, 6'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vt[5]  = '{1'b1, 6'h1C, 32'h1234_5678, 4'h5, 32'h0,         2'b00};
        vt[6]  = '{1'b0, 6'h1C, 32'h0,         4'h0, 32'hFF34_FF78, 2'b00};
        vt[7]  = '{1'b1, 6'h1C, 32'h0,         4'h0, 32'h0,         2'b00};
        vt[8]  = '{1'b0, 6'h1C, 32'h0,         4'h0, 32'hFF34_FF78, 2'b00};
        vt[9]  = '{1'b0, 6'h20, 32'h0,         4'h0, 32'h0,         2'b10};
        vt[10] = '{1'b1, 6'h24, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b10};
        vt[11] = '{1'b0, 6'h1C, 32'h0,         4'h0, 32'hFF34_FF78, 2'b00};
        vt[12] = '{1'b1, 6'h00, 32'h0BAD_0BAD, 4'hF, 32'h0,         2'b00};
        vt[13] = '{1'b0, 6'h00, 32'h0,         4'h0, 32'h5253_0001, 2'b00};
        vt[14] = '{1'b1, 6'h14, 32'h0000_1000, 4'hF, 32'h0,         2'b00};
        vt[15] = '{1'b0, 6'h14, 32'h0,         4'h0, 32'h0000_1000, 2'b00};
        vt[16] = '{1'b1, 6'h14, 32'h0000_00AB, 4'h1, 32'h0,         2'b00};
        vt[17] = '{1'b0, 6'h14, 32'h0,         4'h0, 32'h0000_10AB, 2'b00};
        vt[18] = '{1'b1, 6'h10, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vt[19] = '{1'b0, 6'h10, 32'h0,         4'h0, 32'h0000_0011, 2'b00};
        vt[20] = '{1'b0, 6'h04, 32'h0,         4'h0, 32'h0000_0005, 2'b00};
        vt[21] = '{1'b1, 6'h3C, 32'h1,         4'hF, 32'h0,         2'b10};
        vt[22] = '{1'b1, 6'h10, 32'h0,         4'hF, 32'h0,         2'b00};
        vt[23] = '{1'b0, 6'h10, 32'h0,         4'h0, 32'h0000_0000, 2'b00};

        sys_rst = 1'b1; core_sleep_i = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
        repeat (3) @(negedge sys_clk);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_reboot", reboot_o, 0);
        check("rst_fetch", fetch_enable_o, 0);
        check("rst_boot_addr", boot_addr_o, 32'h0000_0080);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        for (int i = 0; i < 24; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, r, ok);
                check($sformatf("vec%0d_wr_lat", i), ok, 1);
                check($sformatf("vec%0d_bresp", i), r, vt[i].resp);
            end else begin
                axi_read(vt[i].addr, d, r, ok);
                check($sformatf("vec%0d_rd_lat", i), ok, 1);
                check($sformatf("vec%0d_rdata", i), d, vt[i].exp);
                check($sformatf("vec%0d_rresp", i), r, vt[i].resp);
            end
        end

        // Cycle counter under fetch enable, then reboot overriding fetch.
        axi_write(6'h10, 32'h10, 4'hF, r, ok);
        check("fetch_on", fetch_enable_o, 1);
        check("fetch_on_reboot", reboot_o, 0);
        repeat (100) @(negedge sys_clk);
        axi_read(6'h18, d, r, ok);
        n_tests++;
        if (!(d >= 32'd98 && d <= 32'd104)) begin
            n_fail++;
            $display("FAIL cycles_count: got %0d expected 100 +/- 4", d);
        end
        axi_write(6'h10, 32'h11, 4'hF, r, ok);
        check("reboot_fetch", fetch_enable_o, 0);
        check("reboot_on", reboot_o, 1);
        axi_read(6'h18, d, r, ok);
        check("cycles_cleared", d, 0);
        axi_write(6'h10, 32'h00, 4'hF, r, ok);
        check("ctrl0_fetch", fetch_enable_o, 0);
        check("ctrl0_reboot", reboot_o, 0);

        // W three cycles ahead of AW.
        s_axi_wdata = 32'hA5A5_0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        check("wfirst_wready", s_axi_wready, 1);
        @(negedge sys_clk);
        s_axi_wvalid = 1'b0;
        check("wfirst_wready_drop", s_axi_wready, 0);
        repeat (2) @(negedge sys_clk);
        check("wfirst_no_bvalid", s_axi_bvalid, 0);
        s_axi_awaddr = 6'h1C; s_axi_awvalid = 1'b1;
        check("wfirst_awready", s_axi_awready, 1);
        @(negedge sys_clk);
        s_axi_awvalid = 1'b0;
        check("wfirst_bvalid", s_axi_bvalid, 1);
        check("wfirst_bresp", s_axi_bresp, 0);
        s_axi_bready = 1'b1;
        @(negedge sys_clk);
        s_axi_bready = 1'b0;
        check("wfirst_bvalid_drop", s_axi_bvalid, 0);
        axi_read(6'h1C, d, r, ok);
        check("wfirst_data", d, 32'hA5A5_0001);

        // AW ahead of W.
        s_axi_awaddr = 6'h14; s_axi_awvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_awvalid = 1'b0;
        check("awfirst_awready_drop", s_axi_awready, 0);
        repeat (2) @(negedge sys_clk);
        check("awfirst_no_bvalid", s_axi_bvalid, 0);
        s_axi_wdata = 32'h0000_2000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_wvalid = 1'b0;
        check("awfirst_bvalid", s_axi_bvalid, 1);
        check("awfirst_boot_addr", boot_addr_o, 32'h0000_2000);
        s_axi_bready = 1'b1;
        @(negedge sys_clk);
        s_axi_bready = 1'b0;
        repeat (2) begin
            check("awfirst_single_b", s_axi_bvalid, 0);
            @(negedge sys_clk);
        end

        // B backpressure: second AW must wait.
        s_axi_awaddr = 6'h1C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_wvalid = 1'b0;
        s_axi_awaddr = 6'h14;
        check("bp_bvalid", s_axi_bvalid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("bp_bvalid_hold", s_axi_bvalid, 1);
            check("bp_awready", s_axi_awready, 0);
            check("bp_wready", s_axi_wready, 0);
        end
        s_axi_awvalid = 1'b0;
        s_axi_bready = 1'b1;
        @(negedge sys_clk);
        s_axi_bready = 1'b0;
        check("bp_bvalid_drop", s_axi_bvalid, 0);
        check("bp_awready_back", s_axi_awready, 1);
        axi_read(6'h1C, d, r, ok);
        check("bp_scratch", d, 32'h1111_2222);
        check("bp_boot_unchanged", boot_addr_o, 32'h0000_2000);

        // R backpressure.
        s_axi_araddr = 6'h00; s_axi_arvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_arvalid = 1'b0;
        s_axi_araddr = 6'h14;
        held = 32'h5253_0001;
        for (int i = 0; i < 4; i++) begin
            check("rbp_rvalid", s_axi_rvalid, 1);
            check("rbp_rdata", s_axi_rdata, held);
            check("rbp_arready", s_axi_arready, 0);
            @(negedge sys_clk);
        end
        s_axi_rready = 1'b1;
        @(negedge sys_clk);
        s_axi_rready = 1'b0;
        check("rbp_rvalid_drop", s_axi_rvalid, 0);
        check("rbp_arready_back", s_axi_arready, 1);

        // Reset with a write response pending.
        s_axi_awaddr = 6'h10; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h10; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("rstmid_bvalid", s_axi_bvalid, 1);
        check("rstmid_fetch_before", fetch_enable_o, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rstmid_bvalid_clr", s_axi_bvalid, 0);
        check("rstmid_fetch_clr", fetch_enable_o, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        axi_read(6'h10, d, r, ok);
        check("rstmid_ctrl", d, 0);
        axi_read(6'h14, d, r, ok);
        check("rstmid_boot", d, 32'h0000_0080);
        check("rstmid_bvalid_after", s_axi_bvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected completion");
        $fatal(1);
    end

endmodule
